// File: rtl/perceptron_train_sched_if.sv
// perceptron_train_sched_if: bundles the host start/status signals and the
// core/sample-memory signals of the perceptron training sequencer.
//   master modport: the sequencer (drives core_rst, core_control, sample_idx, status)
//   slave modport : the environment (drives start, abort, core_done, core_err)
// Parameter IDX_W sets the width of sample_idx and err_cnt.
interface perceptron_train_sched_if #(
    parameter int unsigned IDX_W = 10
);
    logic             start;
    logic             abort;
    logic             core_done;
    logic             core_err;
    logic             core_rst;
    logic [3:0]       core_control;
    logic [IDX_W-1:0] sample_idx;
    logic             busy;
    logic             done;
    logic             converged;
    logic [7:0]       epoch_cnt;
    logic [IDX_W-1:0] err_cnt;
    logic             timeout;

    modport master (
        input  start, abort, core_done, core_err,
        output core_rst, core_control, sample_idx, busy, done, converged,
               epoch_cnt, err_cnt, timeout
    );

    modport slave (
        output start, abort, core_done, core_err,
        input  core_rst, core_control, sample_idx, busy, done, converged,
               epoch_cnt, err_cnt, timeout
    );
endinterface

// File: rtl/perceptron_train_sched.sv
// perceptron_train_sched: training sequencer for core_perceptron. Walks the
// sample index, pulses the core load/reset, drives the core control word,
// tallies misclassified samples per epoch and repeats epochs until a
// zero-error epoch (optional early stop) or the epoch limit.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-low
//   bus  - perceptron_train_sched_if.master
//          in : start, abort, core_done, core_err
//          out: core_rst, core_control, sample_idx, busy, done, converged,
//               epoch_cnt, err_cnt, timeout (all registered)
//
// Build option: define PERC_EARLY_STOP_EN to finish on the first zero-error
// epoch; otherwise training always runs MAX_EPOCHS epochs.
module perceptron_train_sched #(
    parameter int unsigned NUM_SAMPLES    = 500,
    parameter int unsigned IDX_W          = 10,
    parameter int unsigned MAX_EPOCHS     = 16,
    parameter int unsigned LOAD_CYCLES    = 5,
    parameter int unsigned TIMEOUT_CYCLES = 80
) (
    input logic                     clk,
    input logic                     rst,
    perceptron_train_sched_if.master bus
);

`ifdef PERC_EARLY_STOP_EN
    localparam bit EarlyStop = 1'b1;
`else
    localparam bit EarlyStop = 1'b0;
`endif

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] LoadLast    = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IdxOne      = IDX_W'(1);
    localparam logic [7:0]       MaxEp       = 8'(MAX_EPOCHS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StNext,
        StEpochEnd,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] accum_q, accum_d;
    logic [IDX_W-1:0] err_q, err_d;
    logic [7:0]       epoch_q, epoch_d;
    logic             done_q, done_d;
    logic             conv_q, conv_d;
    logic             tmo_q, tmo_d;
    logic             core_rst_q, core_rst_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            accum_q    <= '0;
            err_q      <= '0;
            epoch_q    <= '0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            tmo_q      <= 1'b0;
            core_rst_q <= 1'b0;
            ctrl_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            accum_q    <= accum_d;
            err_q      <= err_d;
            epoch_q    <= epoch_d;
            done_q     <= done_d;
            conv_q     <= conv_d;
            tmo_q      <= tmo_d;
            core_rst_q <= core_rst_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        accum_d = accum_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        done_d  = done_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;

        if (state_q != StIdle && bus.abort) begin
            // Abort outranks start and core_done; status counters hold.
            state_d = StIdle;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                        idx_d   = '0;
                        epoch_d = '0;
                        err_d   = '0;
                        accum_d = '0;
                        done_d  = 1'b0;
                        conv_d  = 1'b0;
                        tmo_d   = 1'b0;
                    end
                end
                StLoad: begin
                    if (cnt_q == LoadLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StRun: begin
                    // core_done wins over a coincident timeout expiry.
                    if (bus.core_done) begin
                        accum_d = accum_q + IDX_W'(bus.core_err);
                        state_d = StNext;
                    end else if (cnt_q == TimeoutLast) begin
                        tmo_d   = 1'b1;
                        accum_d = accum_q + IdxOne;
                        state_d = StNext;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StNext: begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StEpochEnd;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        state_d = StLoad;
                    end
                end
                StEpochEnd: begin
                    err_d   = accum_q;
                    epoch_d = epoch_q + 8'd1;
                    accum_d = '0;
                    // Always tracks the epoch just completed, so without early
                    // stop it ends up describing the final epoch.
                    conv_d  = (accum_q == '0);
                    if (EarlyStop && accum_q == '0) begin
                        state_d = StFinish;
                    end else if (epoch_q + 8'd1 == MaxEp) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = StLoad;
                    end
                end
                StFinish: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // Registered outputs decoded from the next state so they line up with it.
        core_rst_d = (state_d == StLoad);
        ctrl_d     = (state_d == StRun) ? 4'b1111 : 4'b0000;
        busy_d     = (state_d != StIdle);
    end

    assign bus.core_rst     = core_rst_q;
    assign bus.core_control = ctrl_q;
    assign bus.sample_idx   = idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.converged    = conv_q;
    assign bus.epoch_cnt    = epoch_q;
    assign bus.err_cnt      = err_q;
    assign bus.timeout      = tmo_q;

endmodule

// File: tb/tb_perceptron_train_sched.sv
// tb_perceptron_train_sched: directed bench for perceptron_train_sched.
// Two instances: dut_a (4 samples, 16 epochs, 8-cycle timeout) and dut_b
// (4 samples, 2 epochs). A small core model answers each RUN on its third
// cycle unless told to hang on a sample.
module tb_perceptron_train_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    perceptron_train_sched_if #(.IDX_W(10)) bus_a ();
    perceptron_train_sched_if #(.IDX_W(10)) bus_b ();

    perceptron_train_sched #(
        .NUM_SAMPLES(4), .IDX_W(10), .MAX_EPOCHS(16), .LOAD_CYCLES(5), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    perceptron_train_sched #(
        .NUM_SAMPLES(4), .IDX_W(10), .MAX_EPOCHS(2), .LOAD_CYCLES(5), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

`ifdef PERC_EARLY_STOP_EN
    localparam bit EarlyStop = 1'b1;
`else
    localparam bit EarlyStop = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int err_mode = 0;     // 0: never, 1: sample 2 in epochs 0-1, 2: always
    int hang_sample = -1; // sample for which the core never answers
    int run_a = 0;
    int run_b = 0;
    int n;
    logic [9:0] ep_err [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic want_err(input int ep, input int s);
        case (err_mode)
            1: return (s == 2 && ep < 2);
            2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Core model for dut_a: core_done on the third RUN cycle.
    initial begin
        bus_a.core_done = 1'b0;
        bus_a.core_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.core_control == 4'hF) run_a++; else run_a = 0;
            if (run_a == 3 && int'(bus_a.sample_idx) != hang_sample) begin
                bus_a.core_done = 1'b1;
                bus_a.core_err  = want_err(int'(bus_a.epoch_cnt), int'(bus_a.sample_idx));
            end else begin
                bus_a.core_done = 1'b0;
                bus_a.core_err  = 1'b0;
            end
        end
    end

    // Core model for dut_b.
    initial begin
        bus_b.core_done = 1'b0;
        bus_b.core_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_b.core_control == 4'hF) run_b++; else run_b = 0;
            if (run_b == 3) begin
                bus_b.core_done = 1'b1;
                bus_b.core_err  = want_err(int'(bus_b.epoch_cnt), int'(bus_b.sample_idx));
            end else begin
                bus_b.core_done = 1'b0;
                bus_b.core_err  = 1'b0;
            end
        end
    end

    task automatic start_run(input bit on_b);
        @(negedge clk);
        if (on_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    // Waits for done, logging err_cnt of dut_a as each epoch completes.
    task automatic wait_done(input bit on_b, input int max_cyc);
        int k;
        logic [7:0] prev;
        k = 0;
        prev = bus_a.epoch_cnt;
        while (!(on_b ? bus_b.done : bus_a.done) && k < max_cyc) begin
            @(negedge clk);
            k++;
            if (!on_b && bus_a.epoch_cnt != prev) begin
                prev = bus_a.epoch_cnt;
                if (prev < 8'd32) ep_err[prev[4:0]] = bus_a.err_cnt;
            end
        end
        check("done_within_budget", on_b ? bus_b.done : bus_a.done, 1);
    endtask

    task automatic wait_run_a(input int idx, input int ep, input int max_cyc);
        int k;
        k = 0;
        while (!(bus_a.core_control == 4'hF && int'(bus_a.sample_idx) == idx &&
                 int'(bus_a.epoch_cnt) == ep) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("reach_run", bus_a.core_control, 4'hF);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;

        // Reset state
        #3;
        check("reset_a", {bus_a.core_rst, bus_a.core_control, bus_a.busy, bus_a.done,
                          bus_a.converged, bus_a.timeout, bus_a.epoch_cnt, bus_a.sample_idx,
                          bus_a.err_cnt}, 64'd0);
        check("reset_b", {bus_b.core_rst, bus_b.core_control, bus_b.busy, bus_b.done},
              64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: clean epoch, load length, sample stepping
        err_mode = 0;
        start_run(0);
        check("t1_busy", bus_a.busy, 1);
        for (int s = 0; s < 4; s++) begin
            check("t1_idx", bus_a.sample_idx, s);
            n = 0;
            while (bus_a.core_rst && n < 20) begin n++; @(negedge clk); end
            check("t1_load_len", n, 5);
            check("t1_run_ctrl", bus_a.core_control, 4'hF);
            if (s < 3) begin
                n = 0;
                while (!bus_a.core_rst && n < 20) begin n++; @(negedge clk); end
                check("t1_run_next_len", n, 4);
            end
        end
        wait_done(0, 3000);
        check("t1_epochs", bus_a.epoch_cnt, EarlyStop ? 1 : 16);
        check("t1_err_cnt", bus_a.err_cnt, 0);
        check("t1_converged", bus_a.converged, 1);
        check("t1_timeout", bus_a.timeout, 0);
        check("t1_busy_end", bus_a.busy, 0);
        check("t1_idx_hold", bus_a.sample_idx, 3);

        // 2: errors in epochs 0-1, then clean
        err_mode = 1;
        for (int i = 0; i < 32; i++) ep_err[i] = '1;
        start_run(0);
        check("t2_done_cleared", bus_a.done, 0);
        wait_done(0, 3000);
        check("t2_err_ep1", ep_err[1], 1);
        check("t2_err_ep2", ep_err[2], 1);
        check("t2_err_ep3", ep_err[3], 0);
        check("t2_epochs", bus_a.epoch_cnt, EarlyStop ? 3 : 16);
        check("t2_converged", bus_a.converged, 1);

        // 3: epoch limit on dut_b with every sample wrong
        err_mode = 2;
        start_run(1);
        wait_done(1, 1000);
        check("t3_epochs", bus_b.epoch_cnt, 2);
        check("t3_err_cnt", bus_b.err_cnt, 4);
        check("t3_converged", bus_b.converged, 0);

        // 4: core never answers sample 1
        err_mode = 0;
        hang_sample = 1;
        start_run(0);
        wait_run_a(1, 0, 100);
        n = 0;
        while (bus_a.core_control == 4'hF && n < 50) begin n++; @(negedge clk); end
        check("t4_run_len", n, 8);
        check("t4_timeout", bus_a.timeout, 1);
        n = 0;
        while (!bus_a.core_rst && n < 20) begin n++; @(negedge clk); end
        check("t4_idx_adv", bus_a.sample_idx, 2);
        wait_done(0, 3000);
        check("t4_epochs", bus_a.epoch_cnt, 16);
        check("t4_err_cnt", bus_a.err_cnt, 1);
        check("t4_converged", bus_a.converged, 0);
        check("t4_timeout_end", bus_a.timeout, 1);
        hang_sample = -1;

        // 5a: abort together with core_done and start during RUN
        err_mode = 2;
        start_run(0);
        wait_run_a(0, 1, 200);
        #1;
        bus_a.abort = 1'b1;
        bus_a.core_done = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        check("t5_busy", bus_a.busy, 0);
        check("t5_done", bus_a.done, 0);
        check("t5_ctrl", bus_a.core_control, 0);
        check("t5_core_rst", bus_a.core_rst, 0);
        check("t5_epoch_hold", bus_a.epoch_cnt, 1);
        check("t5_err_hold", bus_a.err_cnt, 4);
        bus_a.abort = 1'b0;
        bus_a.start = 1'b0;
        @(negedge clk);
        check("t5_stay_idle", bus_a.busy, 0);

        // 5b: start and core_done during LOAD are ignored
        err_mode = 0;
        start_run(0);
        @(negedge clk);
        #1;
        bus_a.start = 1'b1;
        bus_a.core_done = 1'b1;
        bus_a.core_err = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        n = 0;
        while (bus_a.core_rst && n < 20) begin n++; @(negedge clk); end
        check("t5_load_rest", n, 3);
        check("t5_load_to_run", bus_a.core_control, 4'hF);
        check("t5_idx", bus_a.sample_idx, 0);

        // 6: asynchronous reset between edges mid-RUN
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_reset", {bus_a.core_rst, bus_a.core_control, bus_a.busy, bus_a.done,
                                 bus_a.converged, bus_a.timeout, bus_a.epoch_cnt,
                                 bus_a.sample_idx, bus_a.err_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_idle_after", bus_a.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_train_sched.md
Name: perceptron_train_sched

Overview:
- Training sequencer for `core_perceptron`.
- Walks the sample index shared by the `x1`, `x2` and `label` memories, pulses the core's load/reset, and drives the core's `control` word.
- Waits for per-sample completion from the core, tallies misclassifications, and repeats epochs until convergence or an epoch limit.
- Sits between the top-level start/status interface and the core plus its sample memories.

Parameters:
- NUM_SAMPLES, 500, samples per epoch; legal range 1..1023.
- IDX_W, 10, width of the sample index.
- MAX_EPOCHS, 16, epoch limit; legal range 1..255.
- LOAD_CYCLES, 5, cycles `core_rst` is held high per sample; must be ≥1.
- TIMEOUT_CYCLES, 80, maximum RUN cycles per sample before the sample is forced to complete.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin training; sampled in IDLE only
- abort  in  1  stop immediately and return to IDLE
- core_done  in  1  core finished the current sample; honoured only in RUN
- core_err  in  1  current sample misclassified; valid with core_done
- core_rst  out  1  load/reset strobe to the core, active-high
- core_control  out  4  control word to the core
- sample_idx  out  IDX_W  address to the x1/x2/label memories
- busy  out  1  high in every state except IDLE
- done  out  1  training finished; held until next accepted start
- converged  out  1  last completed epoch had zero errors
- epoch_cnt  out  8  completed epochs
- err_cnt  out  IDX_W  error count of the last completed epoch
- timeout  out  1  sticky: at least one sample timed out this run

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0; internal error accumulator and timeout counter are 0. Applies mid-operation with no completion of the sample in flight.
- All outputs are registered.

IDLE:
- start=1 at an edge → LOAD.
- On that edge: sample_idx←0, epoch_cnt←0, err_cnt←0, accum←0, done←0, converged←0, timeout←0.
- start while busy is ignored.

LOAD:
- core_rst=1, core_control=0.
- Stays exactly LOAD_CYCLES cycles, then → RUN.

RUN:
- core_rst=0, core_control=4'b1111; the cycle counter increments each cycle.
- core_done=1: accum += core_err → NEXT.
- Otherwise, when the counter reaches TIMEOUT_CYCLES-1: timeout←1, accum += 1 → NEXT.
- core_done coinciding with timeout expiry: core_done wins; timeout is not set.

NEXT (one cycle):
- core_control=0.
- If sample_idx==NUM_SAMPLES-1 → EPOCH_END.
- Else sample_idx+1 → LOAD.

EPOCH_END (one cycle):
- err_cnt←accum, epoch_cnt+1, accum←0.
- If accum==0 (early-stop permitting): converged←1 → FINISH.
- Else if epoch_cnt+1==MAX_EPOCHS → FINISH.
- Else sample_idx←0 → LOAD (wrap).

FINISH (one cycle):
- done←1 → IDLE.
- sample_idx holds its last value.

Abort and timing rules:
- abort=1 in any non-IDLE state → IDLE next edge: core_rst=0, core_control=0, done=0; epoch_cnt/err_cnt/timeout hold.
- abort has priority over start and core_done in the same cycle.
- Per-sample latency: LOAD_CYCLES + (RUN cycles up to and including the core_done cycle) + 1.
- accum never overflows, because NUM_SAMPLES ≤ 2^IDX_W-1.

Optional Feature:
PERC_EARLY_STOP_EN:
- Defined: zero-error epoch → converged=1 and FINISH, as above.
- Undefined: training always runs MAX_EPOCHS epochs. converged still reflects whether the final epoch had err_cnt==0, but never causes an early exit.

Test Plan:
1. Reset/start: NUM_SAMPLES=4, LOAD_CYCLES=5, core_done 3 cycles into each RUN, core_err=0.
   → core_rst high for 5 cycles per sample; sample_idx steps 0,1,2,3.
   → done=1 and converged=1 after epoch_cnt=1, err_cnt=0 (with _EN); without _EN, 16 epochs.
2. Errors then convergence: core_err=1 on sample 2 in epochs 0–1, 0 afterwards.
   → err_cnt=1 after epochs 1 and 2, 0 after epoch 3; done with epoch_cnt=3, converged=1.
3. Epoch limit: MAX_EPOCHS=2, core_err always 1.
   → done with epoch_cnt=2, err_cnt=4, converged=0.
4. Timeout: core_done never asserted for sample 1, TIMEOUT_CYCLES=8.
   → RUN lasts 8 cycles; timeout=1; that sample counts as an error; sample_idx advances to 2.
5. Abort/simultaneity: assert abort and core_done together in RUN.
   → IDLE next cycle, busy=0, done=0, core_control=0.
   → start while busy has no effect; core_done in LOAD is ignored.
6. Async reset mid-RUN: drop rst between clock edges.
   → all outputs 0 immediately, with no clock edge needed.
